// File: rtl/captura_simbolo.sv
// captura_simbolo
// Input stage for the 7-bit symbol sequence recogniser. A raw keypad strobe
// and key index are synchronised, debounced, buffered in a 4-entry FIFO and
// emitted as 7-bit segment codes, paced by a minimum gap between strobes.
//
// Ports
//   clk          in   single clock, all state changes on the rising edge
//   res          in   asynchronous active-low reset
//   tecla_valida in   raw key-pressed level (asynchronous)
//   tecla[3:0]   in   raw key index (asynchronous), valid while tecla_valida=1
//   entrada[6:0] out  segment code of the last emitted key, holds between pulses
//   ctrl         out  one-cycle strobe when a new code is placed on entrada
//   descarte     out  sticky flag: an accepted press was dropped
//   ocupacao[2:0]out  current FIFO fill level, 0..4
module captura_simbolo #(
  parameter int DEB_CYCLES = 16,
  parameter int GAP        = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  output logic [6:0] entrada,
  output logic       ctrl,
  output logic       descarte,
  output logic [2:0] ocupacao
);

  localparam logic [7:0] L_DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] L_GAP      = 8'(GAP);

  typedef enum logic [1:0] {
    S_OCIOSO = 2'd0,
    S_FILTRO = 2'd1,
    S_PRESO  = 2'd2
  } state_t;

  // Synchronisers
  logic       r_v_meta;
  logic       r_v_s;
  logic [3:0] r_k_meta;
  logic [3:0] r_k_s;

  // Debounce FSM
  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic [3:0] r_k_cap;
  logic [3:0] w_k_cap_next;
  logic       w_push;

  // FIFO and pacer
  logic [2:0] r_mem [0:3];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic [2:0] w_count_next;
  logic [7:0] r_gap_cnt;
  logic [6:0] r_entrada;
  logic       r_ctrl;
  logic       r_descarte;

  logic       w_key_ok;
  logic       w_full;
  logic       w_wr_en;
  logic       w_drop;
  logic       w_pop;

  function automatic logic [6:0] f_code(input logic [2:0] key);
    case (key)
      3'd0:    f_code = 7'b0010000;
      3'd1:    f_code = 7'b0100100;
      3'd2:    f_code = 7'b0000010;
      3'd3:    f_code = 7'b1000111;
      3'd4:    f_code = 7'b0111010;
      3'd5:    f_code = 7'b0101001;
      default: f_code = 7'b1111111;
    endcase
  endfunction

  // Debounce next-state logic. cnt counts matching cycles in FILTRO and
  // consecutive released cycles in PRESO.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_k_cap_next = r_k_cap;
    w_push       = 1'b0;
    case (r_state)
      S_OCIOSO: begin
        if (r_v_s) begin
          w_k_cap_next = r_k_s;
          w_cnt_next   = 8'd0;
          w_state_next = S_FILTRO;
        end
      end
      S_FILTRO: begin
        if (!r_v_s || (r_k_s != r_k_cap)) begin
          w_state_next = S_OCIOSO;
        end else if (r_cnt == L_DEB_LAST) begin
          w_push       = 1'b1;
          w_cnt_next   = 8'd0;
          w_state_next = S_PRESO;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_PRESO: begin
        if (r_v_s) begin
          w_cnt_next = 8'd0;
        end else if (r_cnt == L_DEB_LAST) begin
          w_cnt_next   = 8'd0;
          w_state_next = S_OCIOSO;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = S_OCIOSO;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // A full FIFO never makes room through a same-cycle pop: fullness is
  // judged on the registered level.
  assign w_key_ok = (r_k_cap <= 4'd5);
  assign w_full   = (r_count == 3'd4);
  assign w_wr_en  = w_push && w_key_ok && !w_full;
  assign w_drop   = w_push && (!w_key_ok || w_full);
  assign w_pop    = (r_count != 3'd0) && (r_gap_cnt == 8'd0);

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_next = r_count + 3'd1;
      2'b01:   w_count_next = r_count - 3'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_v_meta   <= 1'b0;
      r_v_s      <= 1'b0;
      r_k_meta   <= 4'd0;
      r_k_s      <= 4'd0;
      r_state    <= S_OCIOSO;
      r_cnt      <= 8'd0;
      r_k_cap    <= 4'd0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_gap_cnt  <= 8'd0;
      r_entrada  <= 7'b1111111;
      r_ctrl     <= 1'b0;
      r_descarte <= 1'b0;
    end else begin
      r_v_meta <= tecla_valida;
      r_v_s    <= r_v_meta;
      r_k_meta <= tecla;
      r_k_s    <= r_k_meta;

      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_k_cap  <= w_k_cap_next;

      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_drop) begin
        r_descarte <= 1'b1;
      end
      r_count <= w_count_next;

      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 2'd1;
        r_entrada <= f_code(r_mem[r_rd_ptr]);
        r_ctrl    <= 1'b1;
        r_gap_cnt <= L_GAP;
      end else begin
        r_ctrl <= 1'b0;
        if (r_gap_cnt != 8'd0) begin
          r_gap_cnt <= r_gap_cnt - 8'd1;
        end
      end
    end
  end

  // Storage has no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= r_k_cap[2:0];
    end
  end

  assign entrada  = r_entrada;
  assign ctrl     = r_ctrl;
  assign descarte = r_descarte;
  assign ocupacao = r_count;

endmodule

// File: tb/tb_captura_simbolo.sv
// Bench for captura_simbolo: three instances with different debounce/gap
// settings, a behavioural reference model checked every cycle, and literal
// expectations for pulse timing and codes.
module tb_captura_simbolo;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rs  [N];
  logic       tv  [N];
  logic [3:0] tk  [N];
  logic [6:0] ent [N];
  logic       ctl [N];
  logic       dsc [N];
  logic [2:0] ocp [N];

  // Instance 0: DEB 16 / GAP 4; instance 1: DEB 1 / GAP 4; instance 2: DEB 16 / GAP 255
  captura_simbolo #(.DEB_CYCLES(16), .GAP(4)) u_a (
    .clk(clk), .res(rs[0]), .tecla_valida(tv[0]), .tecla(tk[0]),
    .entrada(ent[0]), .ctrl(ctl[0]), .descarte(dsc[0]), .ocupacao(ocp[0]));
  captura_simbolo #(.DEB_CYCLES(1), .GAP(4)) u_b (
    .clk(clk), .res(rs[1]), .tecla_valida(tv[1]), .tecla(tk[1]),
    .entrada(ent[1]), .ctrl(ctl[1]), .descarte(dsc[1]), .ocupacao(ocp[1]));
  captura_simbolo #(.DEB_CYCLES(16), .GAP(255)) u_c (
    .clk(clk), .res(rs[2]), .tecla_valida(tv[2]), .tecla(tk[2]),
    .entrada(ent[2]), .ctrl(ctl[2]), .descarte(dsc[2]), .ocupacao(ocp[2]));

  function automatic int deb_of(input int i);
    return (i == 1) ? 1 : 16;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 2) ? 255 : 4;
  endfunction

  function automatic logic [6:0] seg(input int k);
    case (k)
      0:       return 7'b0010000;
      1:       return 7'b0100100;
      2:       return 7'b0000010;
      3:       return 7'b1000111;
      4:       return 7'b0111010;
      5:       return 7'b0101001;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model state
  int         m_s1   [N];
  int         m_s2   [N];
  int         m_k1   [N];
  int         m_k2   [N];
  int         m_key  [N];
  int         m_run  [N];
  int         m_low  [N];
  bit         m_armed[N];
  int         m_list [N][8];
  int         m_len  [N];
  int         m_gap  [N];
  bit         m_ctrl [N];
  logic [6:0] m_ent  [N];
  bit         m_desc [N];

  // Model: a press is accepted once the synchronised level has been high with
  // one key for DEB+1 sampled edges; after that, DEB consecutive low edges
  // re-arm it. A FIFO list drains one entry per GAP+1 cycles.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rs[i]) begin
        m_s1[i] = 0; m_s2[i] = 0; m_k1[i] = 0; m_k2[i] = 0;
        m_key[i] = 0; m_run[i] = 0; m_low[i] = 0; m_armed[i] = 1'b1;
        m_len[i] = 0; m_gap[i] = 0; m_ctrl[i] = 1'b0;
        m_ent[i] = 7'b1111111; m_desc[i] = 1'b0;
      end else begin
        bit push;
        bit full;
        int pk;
        push = 1'b0;
        pk   = m_key[i];
        if (m_armed[i]) begin
          if (m_s2[i] == 1 && m_run[i] == 0) begin
            m_key[i] = m_k2[i];
            m_run[i] = 1;
          end else if (m_s2[i] == 1 && m_k2[i] == m_key[i]) begin
            if (m_run[i] == deb_of(i)) begin
              push = 1'b1;
              pk = m_key[i];
              m_armed[i] = 1'b0;
              m_run[i] = 0;
              m_low[i] = 0;
            end else begin
              m_run[i]++;
            end
          end else begin
            m_run[i] = 0;
          end
        end else begin
          if (m_s2[i] == 1) begin
            m_low[i] = 0;
          end else begin
            m_low[i]++;
            if (m_low[i] == deb_of(i)) begin
              m_armed[i] = 1'b1;
              m_low[i] = 0;
            end
          end
        end
        full = (m_len[i] == 4);
        if (m_len[i] > 0 && m_gap[i] == 0) begin
          m_ent[i] = seg(m_list[i][0]);
          for (int j = 0; j < 7; j++) m_list[i][j] = m_list[i][j+1];
          m_len[i]--;
          m_ctrl[i] = 1'b1;
          m_gap[i] = gap_of(i);
        end else begin
          m_ctrl[i] = 1'b0;
          if (m_gap[i] > 0) m_gap[i]--;
        end
        if (push) begin
          if (pk > 5 || full) begin
            m_desc[i] = 1'b1;
          end else begin
            m_list[i][m_len[i]] = pk;
            m_len[i]++;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(tv[i]);
        m_k2[i] = m_k1[i];
        m_k1[i] = int'(tk[i]);
      end
    end
  end

  int         nvec = 0;
  int         nerr = 0;
  int         cycle = 0;
  int         pn   [N];
  int         pt   [N][16];
  logic [6:0] pc   [N][16];
  int         omax [N];

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst %0d cycle %0d: got %0h, expected %0h",
               name, inst, cycle, act, exp);
    end
  endtask

  task automatic clear(input int i);
    pn[i] = 0;
    omax[i] = 0;
    for (int j = 0; j < 16; j++) begin
      pt[i][j] = -1;
      pc[i][j] = 7'd0;
    end
  endtask

  // One clock: compare every instance against the model, log pulses.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cycle++;
      for (int i = 0; i < N; i++) begin
        check("entrada",  i, 32'(ent[i]), 32'(m_ent[i]));
        check("ctrl",     i, 32'(ctl[i]), 32'(m_ctrl[i]));
        check("descarte", i, 32'(dsc[i]), 32'(m_desc[i]));
        check("ocupacao", i, 32'(ocp[i]), 32'(m_len[i]));
        if (int'(ocp[i]) > omax[i]) omax[i] = int'(ocp[i]);
        if (ctl[i]) begin
          $display("inst %0d cycle %0d: ctrl pulse entrada=%b ocupacao=%0d",
                   i, cycle, ent[i], ocp[i]);
          if (pn[i] < 16) begin
            pt[i][pn[i]] = cycle;
            pc[i][pn[i]] = ent[i];
            pn[i]++;
          end
        end
      end
    end
  endtask

  initial begin
    int t0;
    int keys [3];
    keys = '{0, 2, 3};
    for (int i = 0; i < N; i++) begin
      rs[i] = 1'b0; tv[i] = 1'b0; tk[i] = 4'd0;
      clear(i);
    end

    // Reset values
    cyc(3);
    check("rst_entrada",  0, 32'(ent[0]), 32'h7F);
    check("rst_ctrl",     0, 32'(ctl[0]), 32'd0);
    check("rst_descarte", 0, 32'(dsc[0]), 32'd0);
    check("rst_ocupacao", 0, 32'(ocp[0]), 32'd0);
    for (int i = 0; i < N; i++) rs[i] = 1'b1;
    cyc(5);

    // Clean press of key 1, held 40 cycles
    clear(0);
    t0 = cycle;
    tk[0] = 4'd1; tv[0] = 1'b1;
    cyc(40);
    tv[0] = 1'b0;
    cyc(40);
    check("clean_pulses", 0, 32'(pn[0]), 32'd1);
    check("clean_time",   0, 32'(pt[0][0] - t0), 32'd20);
    check("clean_code",   0, 32'(pc[0][0]), 32'b0100100);

    // Bounced press: 10 high, 3 low, 10 high
    clear(0);
    tk[0] = 4'd2; tv[0] = 1'b1; cyc(10);
    tv[0] = 1'b0; cyc(3);
    tv[0] = 1'b1; cyc(10);
    tv[0] = 1'b0; cyc(40);
    check("bounce_pulses", 0, 32'(pn[0]), 32'd0);
    check("bounce_ocup",   0, 32'(omax[0]), 32'd0);

    // Pacing: keys 0,2,3 pushed every 4 cycles, drained every 5
    clear(1);
    for (int k = 0; k < 3; k++) begin
      tk[1] = 4'(keys[k]); tv[1] = 1'b1; cyc(3);
      tv[1] = 1'b0; cyc(1);
    end
    cyc(30);
    check("pace_pulses", 1, 32'(pn[1]), 32'd3);
    check("pace_gap1",   1, 32'(pt[1][1] - pt[1][0]), 32'd5);
    check("pace_gap2",   1, 32'(pt[1][2] - pt[1][1]), 32'd5);
    check("pace_code0",  1, 32'(pc[1][0]), 32'b0010000);
    check("pace_code1",  1, 32'(pc[1][1]), 32'b0000010);
    check("pace_code2",  1, 32'(pc[1][2]), 32'b1000111);

    // Overflow with the pacer stalled by GAP=255
    clear(2);
    for (int j = 0; j < 6; j++) begin
      tk[2] = 4'(j); tv[2] = 1'b1; cyc(20);
      tv[2] = 1'b0; cyc(20);
      if (j == 4) begin
        check("ovf_full_ocup",  2, 32'(ocp[2]), 32'd4);
        check("ovf_full_desc",  2, 32'(dsc[2]), 32'd0);
      end
    end
    check("ovf_pulses", 2, 32'(pn[2]), 32'd1);
    check("ovf_code",   2, 32'(pc[2][0]), 32'b0010000);
    check("ovf_ocup",   2, 32'(ocp[2]), 32'd4);
    check("ovf_desc",   2, 32'(dsc[2]), 32'd1);

    // Reset clears everything; then invalid key 9 on an empty FIFO
    rs[2] = 1'b0; cyc(2);
    rs[2] = 1'b1; cyc(2);
    check("rst2_desc", 2, 32'(dsc[2]), 32'd0);
    check("rst2_ocup", 2, 32'(ocp[2]), 32'd0);
    clear(2);
    tk[2] = 4'd9; tv[2] = 1'b1; cyc(20);
    tv[2] = 1'b0; cyc(20);
    check("inv_desc",   2, 32'(dsc[2]), 32'd1);
    check("inv_ocup",   2, 32'(omax[2]), 32'd0);
    check("inv_pulses", 2, 32'(pn[2]), 32'd0);

    // Reset in the middle of FILTRO, key held through and after reset
    clear(0);
    tk[0] = 4'd4; tv[0] = 1'b1; cyc(8);
    rs[0] = 1'b0; cyc(2);
    rs[0] = 1'b1;
    clear(0);
    t0 = cycle;
    cyc(40);
    tv[0] = 1'b0; cyc(40);
    check("rstmid_pulses", 0, 32'(pn[0]), 32'd1);
    check("rstmid_time",   0, 32'(pt[0][0] - t0), 32'd20);
    check("rstmid_code",   0, 32'(pc[0][0]), 32'b0111010);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/captura_simbolo.md
# captura_simbolo

- Upstream input stage for the 7-bit symbol sequence recogniser.
- Takes a raw, asynchronous keypad strobe and 4-bit key index, synchronises and debounces them, and buffers accepted keys in a 4-entry FIFO.
- Translates each key into its 7-bit segment code and presents it on `entrada` with a one-cycle `ctrl` strobe, paced by a minimum gap.
- Outputs change only on rising `clk`, so they are stable at the falling edge where the recogniser samples them.

## Interface
- `DEB_CYCLES`, 16: consecutive synchronised cycles a press or release must be stable to be accepted; legal range 1..255.
- `GAP`, 4: idle cycles forced after each `ctrl` pulse; legal range 0..255.
- `clk` input 1: single clock; all state changes on rising edge.
- `res` input 1: reset, asynchronous, active-low.
- `tecla_valida` input 1: raw key-pressed level, asynchronous to `clk`.
- `tecla` input 4: raw key index, asynchronous; meaningful while `tecla_valida` is high.
- `entrada` output 7: segment code of the last emitted key; holds between pulses.
- `ctrl` output 1: high for exactly one cycle when a new code is placed on `entrada`.
- `descarte` output 1: sticky flag, set when an accepted press is dropped; cleared only by `res`.
- `ocupacao` output 3: current FIFO fill level, 0..4.

## Operation
- **Synchroniser:** `tecla_valida` and `tecla` each pass through a two-flop synchroniser, giving `v_s` and `k_s`.
- **Debounce FSM, 8-bit counter `cnt`:**
  - OCIOSO: when `v_s`=1, capture `k_s` into `k_cap`, set `cnt`=0, go to FILTRO.
  - FILTRO: if `v_s`=0 or `k_s`≠`k_cap`, return to OCIOSO. Otherwise increment `cnt`. When `cnt`=DEB_CYCLES-1 with `v_s`=1 and the key unchanged, issue one push request for `k_cap` and go to PRESO.
  - PRESO: wait for release. `cnt` counts consecutive `v_s`=0 cycles and is reset to 0 whenever `v_s`=1. When `cnt` reaches DEB_CYCLES-1, go to OCIOSO.
- **Key to code map:**
  - 0 -> 0010000
  - 1 -> 0100100
  - 2 -> 0000010
  - 3 -> 1000111
  - 4 -> 0111010
  - 5 -> 0101001
  - Keys 6..15 are invalid.
- **Push handling:**
  - Invalid key, or FIFO full (`ocupacao`=4): no write, set `descarte`.
  - Otherwise write the key into the FIFO.
  - A held key produces exactly one push.
- **FIFO:** 4 entries × 3 bits, read and write pointers wrap modulo 4. A push and a pop in the same cycle are both performed and `ocupacao` is unchanged. A push into a full FIFO is never combined with a pop to make room; it is dropped.
- **Output pacer, 8-bit `gap_cnt`:**
  - When the FIFO is non-empty and `gap_cnt`=0: pop, drive `entrada`=code(entry), assert `ctrl` for one cycle, load `gap_cnt`=GAP.
  - Otherwise `ctrl`=0 and `gap_cnt` decrements to 0.
- **Reset values:**
  - `entrada`=1111111 (blank), `ctrl`=0, `descarte`=0, `ocupacao`=0.
  - FSM in OCIOSO, pointers, `cnt` and `gap_cnt` at 0, synchronisers at 0.
- **Reset mid-operation:** asserting `res` during FILTRO, PRESO or a pending pop discards everything immediately; no `ctrl` pulse follows reset release until a new full debounce completes.

## Timing
- Edge 1 is the first rising edge that samples `tecla_valida`=1. With the FIFO empty and `gap_cnt`=0:
  - `v_s`=1 after edge 2.
  - FILTRO entered at edge 3.
  - Push at edge DEB_CYCLES+3.
  - `ctrl`=1 and the new `entrada` after edge DEB_CYCLES+4, `ctrl` back to 0 after edge DEB_CYCLES+5.
- Latency from accepted push to `ctrl` is 1 cycle when idle.
- Consecutive `ctrl` pulses are at least GAP+1 cycles apart. GAP=0 allows back-to-back pulses, one per cycle.
- A press shorter than DEB_CYCLES synchronised cycles, or one whose key changes during FILTRO, produces no push.
- A release bounce shorter than DEB_CYCLES cycles does not re-arm the FSM.
- `descarte` sets on the edge of the dropped push.
- `ocupacao` updates on the edge of the push or pop.

## Test plan
- **Reset values:** hold `res`=0 → `entrada`=1111111, `ctrl`=0, `ocupacao`=0, `descarte`=0.
- **Clean press, DEB_CYCLES=16:** `tecla`=1, `tecla_valida` high 40 cycles → single `ctrl` pulse after edge 20 with `entrada`=0100100, no second pulse while held.
- **Bounce reject:** `tecla_valida` high for 10 cycles, low for 3, high for 10 → no push, `ocupacao` stays 0.
- **Pacing, GAP=4:** keys 0,2,3 pressed faster than the pacer drains → pulses exactly 5 cycles apart with codes 0010000, 0000010, 1000111.
- **Overflow and invalid key, pacer stalled by GAP=255:** six valid presses → `ocupacao` reaches 4, `descarte`=1 on the 6th push (the 1st press is popped immediately, leaving 5 to fit in 4 entries). Separately, key 9 pressed with the FIFO empty → `descarte`=1, no pulse.
- **Reset mid-debounce:** assert `res` during FILTRO, release, hold the key steady → exactly one pulse, DEB_CYCLES+4 edges after the first post-reset edge that samples the key high.
